prbs_burst_ctrl: RTL and testbench
==================================

Name: prbs_burst_ctrl

Overview:
Sequencer for the lab's Fibonacci-LFSR PRBS generator. Takes a seed and burst length from the host, loads the LFSR, and steps it once per clock-enable tick from the clock divider. Emits exactly burst_len bits and signals completion. Also measures the LFSR period: the shift count until the state returns to the seed. Sits between the front-panel/host control logic and the LFSR datapath, replacing free-running operation with controlled bursts.

Parameters:
WIDTH, 3, LFSR register width (>=2)
TAPS, 3'b101, feedback tap mask; feedback = XOR of q bits where TAPS bit is 1
LEN_W, 16, width of burst length, shift counter and period

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  single-cycle step enable from the clock divider
start  in  1  begin a burst (sampled in IDLE only)
abort  in  1  terminate the active burst
seed  in  WIDTH  initial LFSR state, sampled on accepted start
burst_len  in  LEN_W  number of bits to emit, sampled on accepted start
lfsr_q  out  WIDTH  current LFSR state
bit_out  out  1  PRBS bit (lfsr_q[WIDTH-1] before the shift)
bit_valid  out  1  high for the one cycle in which a shift occurs
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse at normal burst completion
seed_err  out  1  one-cycle pulse when start is rejected for seed==0
period  out  LEN_W  measured period, valid when period_valid
period_valid  out  1  sticky; cleared on accepted start

Behaviour:
- Reset (async): state=IDLE, lfsr_q=0, count=0, period=0, all 1-bit outputs 0.
- FSM states IDLE, LOAD, RUN, DONE.
- IDLE + start, seed!=0: latch seed and burst_len; clear count, period and period_valid; go to LOAD next cycle.
- IDLE + start, seed==0: pulse seed_err for one cycle (all-zero LFSR lock-up); remain in IDLE with all other state unchanged.
- LOAD: one cycle; lfsr_q <= seed_latched. Then go to DONE if burst_len_latched==0, else to RUN.
- RUN, on each cycle with tick=1:
  - lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  - bit_out = old lfsr_q[WIDTH-1], registered so it appears with bit_valid;
  - count++.
- RUN, tick=0: hold everything; bit_valid=0.
- Period capture: on a RUN shift where the next state == seed_latched and period_valid==0, set period = count+1 and period_valid=1. Later returns to the seed are ignored. If the burst ends first, period_valid stays 0.
- RUN exit: when a shift makes count+1 == burst_len_latched, go to DONE after that shift.
- DONE: pulse done for one cycle, then go to IDLE. lfsr_q holds its final state.
- abort in LOAD or RUN: go to IDLE next cycle with no done pulse and no shift that cycle. lfsr_q holds its value; period and period_valid hold theirs. abort has priority over tick. abort in IDLE or DONE is ignored.
- start while busy or in DONE is ignored; there is no queueing.
- Latency: accepted start -> lfsr_q==seed after 2 clocks. First bit_valid comes at the first tick in RUN, earliest 3 clocks after start.
- count wraps modulo 2^LEN_W. It cannot exceed burst_len, so wrap is unreachable in normal use.
- busy deasserts in the same cycle the state leaves RUN/LOAD.

Decomposition:
- Shared package prbs_pkg: FSM state enum (IDLE/LOAD/RUN/DONE, 2-bit encoding) and DEFAULT_TAPS_3 = 3'b101.
- Sub-module prbs_lfsr_core(WIDTH, TAPS): ports clk, rst, load, load_val, shift, q. Holds the LFSR register and feedback XOR. The controller owns the FSM, counter, period capture and output pulses.

Test Plan:
- seed=3'b001, burst_len=7, tick every cycle -> bit_out sequence 0,0,1,1,1,0,1; states 011,111,110,101,010,100,001; period=7, period_valid=1; single done pulse.
- seed=3'b001, burst_len=3, tick every 4th cycle -> exactly 3 bit_valid pulses, each on a tick cycle; done follows the 3rd; period_valid=0; final lfsr_q=3'b110.
- seed=3'b000 with start -> seed_err pulse, busy stays 0, no done, lfsr_q unchanged.
- burst_len=0, seed=3'b100 -> LOAD then DONE; done pulse with zero bit_valid; lfsr_q=3'b100.
- abort after 2 shifts of a 7-bit burst (seed=001) -> IDLE next cycle, no done, lfsr_q=3'b111; start during the burst ignored; a fresh start afterwards is accepted and clears period_valid.
- Async rst asserted mid-RUN between clock edges -> all outputs 0 immediately, state IDLE. abort and tick in the same RUN cycle -> no shift occurs.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared FSM state encoding and default tap mask for the PRBS burst sequencer.
package prbs_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [2:0] DEFAULT_TAPS_3 = 3'b101;
endpackage

// File: rtl/prbs_lfsr_core.sv
// prbs_lfsr_core: Fibonacci LFSR register with parallel load and single-step shift.
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS_3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (load) q <= load_val;
        else if (shift) q <= {q[WIDTH-2:0], ^(q & TAPS)};
endmodule

// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl: loads a seeded LFSR, emits burst_len PRBS bits on divider ticks
// and measures the shift count until the state returns to the seed.
module prbs_burst_ctrl
    import prbs_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS_3),
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] burst_len,
    output logic [WIDTH-1:0] lfsr_q,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             seed_err,
    output logic [LEN_W-1:0] period,
    output logic             period_valid
);
    state_t state, state_d;
    logic [WIDTH-1:0] seed_l, q_next;
    logic [LEN_W-1:0] len_l, count, cnt_inc;
    logic accept, shift, load;

    assign accept  = state == IDLE && start && |seed;
    assign shift   = state == RUN && tick && !abort;
    assign load    = state == LOAD && !abort;
    assign q_next  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign cnt_inc = count + LEN_W'(1);
    assign busy    = state == LOAD || state == RUN;
    assign done    = state == DONE;

    prbs_lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
        .clk(clk), .rst(rst), .load(load), .load_val(seed_l), .shift(shift), .q(lfsr_q)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_d;

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: state_d = accept ? LOAD : IDLE;
            LOAD: state_d = abort ? IDLE : (len_l == '0) ? DONE : RUN;
            RUN:  state_d = abort ? IDLE : (tick && cnt_inc == len_l) ? DONE : RUN;
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            seed_l       <= '0;
            len_l        <= '0;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            seed_err     <= 1'b0;
        end else begin
            bit_valid <= shift;
            seed_err  <= state == IDLE && start && seed == '0;
            if (shift) bit_out <= lfsr_q[WIDTH-1];
            if (accept) begin
                seed_l       <= seed;
                len_l        <= burst_len;
                count        <= '0;
                period       <= '0;
                period_valid <= 1'b0;
            end
            if (shift) begin
                count <= cnt_inc;
                // only the first return to the seed defines the period
                if (q_next == seed_l && !period_valid) begin
                    period       <= cnt_inc;
                    period_valid <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl: randomized bursts checked by a queue scoreboard against a behavioural LFSR model.
module tb_prbs_burst_ctrl;
    localparam int W = 3;
    localparam int LW = 16;
    localparam logic [W-1:0] TAPS_M = 3'b101;

    logic clk = 0, rst = 1, tick = 0, start = 0, abort = 0;
    logic [W-1:0] seed = '0;
    logic [LW-1:0] burst_len = '0;
    logic [W-1:0] lfsr_q;
    logic bit_out, bit_valid, busy, done, seed_err, period_valid;
    logic [LW-1:0] period;

    prbs_burst_ctrl #(.WIDTH(W), .TAPS(TAPS_M), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort), .seed(seed),
        .burst_len(burst_len), .lfsr_q(lfsr_q), .bit_out(bit_out), .bit_valid(bit_valid),
        .busy(busy), .done(done), .seed_err(seed_err), .period(period), .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic b; logic [W-1:0] s;} bit_t;
    typedef struct packed {logic [W-1:0] s; logic pv; logic [LW-1:0] p;} done_t;
    bit_t bq[$];
    done_t dq[$];
    int checks = 0, errs = 0, shots = 0;
    bit done_seen = 0;
    logic tick_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] nxt(input logic [W-1:0] s);
        int fb;
        fb = $countones(s & TAPS_M) % 2;
        return W'(((int'(s) * 2) + fb) % (1 << W));
    endfunction

    task automatic model(input logic [W-1:0] s0, input int n, input bit fin);
        logic [W-1:0] s;
        logic pv;
        int p;
        s = s0; pv = 0; p = 0;
        for (int i = 0; i < n; i++) begin
            bq.push_back(bit_t'{s[W-1], nxt(s)});
            s = nxt(s);
            if (!pv && s == s0) begin pv = 1; p = i + 1; end
        end
        if (fin) dq.push_back(done_t'{s, pv, LW'(p)});
    endtask

    always @(posedge clk) tick_edge <= tick;

    always @(negedge clk) if (!rst) begin
        if (bit_valid) begin
            bit_t e;
            shots++;
            check("bit_on_tick", tick_edge, 1);
            if (bq.size() == 0) begin
                checks++; errs++;
                $display("FAIL extra_bit: got bit_valid=1 expected no shift");
            end else begin
                e = bq.pop_front();
                check("bit_out", bit_out, e.b);
                check("lfsr_after_shift", lfsr_q, e.s);
            end
        end
        if (done) begin
            done_t d;
            done_seen = 1;
            if (dq.size() == 0) begin
                checks++; errs++;
                $display("FAIL extra_done: got done=1 expected none");
            end else begin
                d = dq.pop_front();
                check("final_lfsr", lfsr_q, d.s);
                check("period_valid", period_valid, d.pv);
                if (d.pv) check("period", period, d.p);
            end
        end
    end

    task automatic burst(input logic [W-1:0] sd, input int len, input int mode);
        logic [W-1:0] prev;
        int cyc, s0;
        @(posedge clk); #1;
        start = 1; seed = sd; burst_len = LW'(len); tick = 0;
        prev = lfsr_q; s0 = shots; done_seen = 0;
        if (sd != 0) model(sd, len, 1);
        @(posedge clk); #1;
        start = 0;
        if (sd == 0) begin
            check("seed_err_pulse", seed_err, 1);
            check("seed_err_busy", busy, 0);
            @(posedge clk); #1;
            check("seed_err_clear", seed_err, 0);
            check("seed_err_lfsr", lfsr_q, prev);
            check("seed_err_no_done", done_seen, 0);
            return;
        end
        check("busy_on_start", busy, 1);
        check("pv_cleared", period_valid, 0);
        tick = $urandom_range(0, 1);
        @(posedge clk); #1;
        check("load_latency", lfsr_q, sd);
        cyc = 0;
        while (!done_seen && cyc < 2000) begin
            tick = (mode == 0) ? ($urandom_range(0, 2) != 0) : (cyc % mode == 0);
            cyc++;
            @(posedge clk); #1;
        end
        tick = 0;
        check("done_seen", done_seen, 1);
        @(posedge clk); #1;
        check("idle_after_done", busy, 0);
        check("bit_count", shots - s0, len);
    endtask

    initial begin
        #12;
        check("rst_lfsr", lfsr_q, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {done, bit_valid, seed_err, period_valid, bit_out}, 0);
        check("rst_period", period, 0);
        @(negedge clk); rst = 0;

        burst(3'b001, 7, 1);
        burst(3'b001, 3, 4);
        burst(3'b000, 5, 1);
        burst(3'b100, 0, 1);
        burst(3'b001, 7, 1);

        begin
            int s0;
            s0 = shots; done_seen = 0;
            model(3'b001, 2, 0);
            @(posedge clk); #1; start = 1; seed = 3'b001; burst_len = 7; tick = 1;
            @(posedge clk); #1; start = 0;
            check("abort_pv_cleared", period_valid, 0);
            @(posedge clk); #1; start = 1; seed = 3'b101;
            @(posedge clk); #1; start = 0;
            @(posedge clk); #1; abort = 1; tick = 1;
            @(posedge clk); #1; abort = 0; tick = 0;
            check("abort_busy", busy, 0);
            @(posedge clk); #1;
            check("abort_lfsr", lfsr_q, 3'b111);
            check("abort_shots", shots - s0, 2);
            check("abort_no_done", done_seen, 0);
        end
        burst(3'b001, 7, 1);

        for (int i = 0; i < 20; i++)
            burst(W'($urandom_range(0, 7)), $urandom_range(0, 20), $urandom_range(0, 3));

        model(3'b001, 20, 1);
        @(posedge clk); #1; start = 1; seed = 3'b001; burst_len = 20; tick = 1;
        @(posedge clk); #1; start = 0;
        repeat (4) @(posedge clk);
        #3; rst = 1;
        #1;
        check("arst_lfsr", lfsr_q, 0);
        check("arst_busy", busy, 0);
        check("arst_outs", {done, bit_valid, seed_err, period_valid}, 0);
        bq.delete(); dq.delete();
        tick = 0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        check("arst_idle", busy, 0);

        check("bits_drained", bq.size(), 0);
        check("dones_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", checks - errs, checks);
        $finish;
    end
endmodule
